bp_btb_assoc: RTL and testbench
===============================

# bp_btb_assoc

Set-associative branch target buffer with branch history counters, used as the fetch-stage branch predictor of the pipelined ARM core. It supersedes the direct-mapped BHT-BTB. Set count, associativity and counter width are parameters, and victims are chosen by tree pseudo-LRU replacement. Every resolved branch trains the predictor, not only mispredicted ones. A multi-cycle invalidate sweep is provided for context or code changes.

## Interface
- `ENTRY_BITS`, default 4: set index width. Sets = 2^ENTRY_BITS, and the index is PC[ENTRY_BITS+1:2].
- `WAYS`, default 2: associativity. Legal values are 1, 2, 4 and 8.
- `CTR_BITS`, default 2: width of the saturating prediction counter, minimum 2.

Ports:
- `clk` in 1: the single clock. Rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `PC_F` in 32: fetch PC.
- `PrPCSrc_F` out 1: predicted taken.
- `PrALUResult_F` out 32: predicted target. Value is 0 when not taken.
- `Branch_E` in 1: a conditional or unconditional branch is resolved in Execute this cycle.
- `PC_E` in 32: PC of the resolved branch.
- `PCSrc_E` in 1: actual outcome, 1 = taken.
- `ALUResult_E` in 32: actual target.
- `Flush_req` in 1: single-cycle pulse that starts the invalidate sweep.
- `Busy` out 1: a sweep is in progress.
- `Stat_Upd`, `Stat_Alloc`, `Stat_Hit` out 32 each: present only with `BP_STATS_EN`.

## Operation
- Tag = PC[31:ENTRY_BITS+2], which is 30−ENTRY_BITS bits.
- Each way of each set stores valid, tag, target (32 bits) and counter (CTR_BITS).
- Each set also stores a WAYS−1 bit tree-PLRU state.
- Threshold T = 2^(CTR_BITS−1).

Fetch lookup (combinational):
- A hit is a valid way whose tag matches PC_F.
- Predict taken when the matching way's counter ≥ T. In that case PrPCSrc_F=1 and PrALUResult_F is the stored target.
- Otherwise both outputs are 0.
- While `Busy`=1, both outputs are forced to 0.

Execute update (when Branch_E=1 and Busy=0):
- Hit: counter is incremented if PCSrc_E=1, otherwise decremented, saturating at 0 and at 2^CTR_BITS−1. Target is overwritten with ALUResult_E only if PCSrc_E=1. The PLRU state is touched toward this way.
- Miss with PCSrc_E=1: allocate into a way. Use the lowest-numbered invalid way if one exists, otherwise the PLRU victim. Write valid=1, tag, target and counter=T. The PLRU state is touched toward the allocated way.
- Miss with PCSrc_E=0: no state change.
- Fetch lookups never modify PLRU state.

Sweep FSM, states IDLE and SWEEP:
- In IDLE, Flush_req=1 moves to SWEEP with the sweep index at 0.
- In SWEEP, one set per cycle is processed: its valid bits and PLRU state are cleared, then the index increments.
- After set 2^ENTRY_BITS−1 is cleared, the FSM returns to IDLE.
- Flush_req while in SWEEP is ignored.
- Branch_E while in SWEEP is dropped.

Reset:
- All valid bits, PLRU states and the sweep index are cleared to 0.
- All counters are set to T−1.
- FSM goes to IDLE.
- Reset values of outputs: PrPCSrc_F=0, PrALUResult_F=0, Busy=0, all Stat counters 0.

## Timing
- Prediction latency is zero: outputs depend combinationally on PC_F and the current state.
- Updates commit on the rising edge. A fetch of the same set in the same cycle sees the pre-update contents.
- Flush_req sampled at edge k gives Busy=1 from edge k through edge k+2^ENTRY_BITS, which is 2^ENTRY_BITS cycles. Busy is low again after that.
- Flush_req and Branch_E in the same cycle: the flush wins and the update is dropped.
- Reset asserted mid-sweep clears everything asynchronously, and Busy drops immediately.
- Addresses do not wrap. The index and tag are pure bit slices of the PC.

## Configuration
- `BP_STATS_EN` defined: three 32-bit wrapping counters are compiled in and output.
  - `Stat_Upd` counts accepted updates.
  - `Stat_Alloc` counts allocations.
  - `Stat_Hit` counts Execute hits.
  - All three are cleared by reset and by the start of a sweep.
- Not defined: the Stat ports and their logic are absent. Functional behaviour is otherwise identical.

## Structure
- Package `bp_pkg` holds:
  - counter threshold and saturation constants as functions of CTR_BITS;
  - the sweep state enum (IDLE, SWEEP);
  - the legal-WAYS check.
- Sub-module `bp_plru`: purely combinational. Given a set's PLRU bits it produces the victim way, and given an access way it produces the next PLRU bits. It is instantiated once and shared by the Execute path.

## Test plan
All scenarios use ENTRY_BITS=4, WAYS=2, CTR_BITS=2, so T=2.

- **Reset state:** release reset, PC_F=0x100 → PrPCSrc_F=0, PrALUResult_F=0, Busy=0.
- **Allocate then predict:** Branch_E=1, PC_E=0x40, PCSrc_E=1, ALUResult_E=0x200 → next cycle PC_F=0x40 gives PrPCSrc_F=1 and PrALUResult_F=0x200. PC_F=0x44 still misses.
- **Replacement:** allocate 0x40, then 0x80 (both set 0), then a taken update at 0x80 → a taken allocation at 0xC0 evicts 0x40. Result: 0x40 misses, 0x80 and 0xC0 predict taken.
- **Counter saturation:** after allocating 0x40 (counter 2), one not-taken update gives counter 1 and a PrPCSrc_F=0 prediction. Three taken updates then give counter 3 and taken. One further not-taken update gives counter 2, still taken.
- **Flush:**
  - Pulse Flush_req with entries valid → Busy=1 for exactly 16 cycles and predictions are 0 throughout.
  - A taken Branch_E at sweep cycle 3 is dropped.
  - After the sweep, every prior PC misses.
- **Reset mid-sweep and stats:** assert RESET_N=0 at sweep cycle 5 → Busy=0 immediately. With BP_STATS_EN, one allocation followed by one hit gives Stat_Upd=2, Stat_Alloc=1, Stat_Hit=1.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared definitions for the associative branch target buffer:
//            counter threshold/saturation helpers, sweep state encoding and
//            the associativity legality check.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Smallest counter value that predicts taken.
    function automatic int ctr_thresh(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    // Upper saturation value of the prediction counter.
    function automatic int ctr_max(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

    function automatic bit ways_legal(input int ways);
        return (ways == 1) || (ways == 2) || (ways == 4) || (ways == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_plru.sv
`default_nettype none
// ============================================================================
// Module   : bp_plru
// Purpose  : Combinational tree pseudo-LRU helper for one set.
//            Node bits are stored heap-ordered (node 0 = root, children of
//            node n are 2n+1 / 2n+2). A node bit of 0 points the victim
//            search to the lower half, 1 to the upper half.
// Ports    : plru_bits  - current tree state of the set
//            victim     - way the tree currently points at
//            access_way - way being touched
//            next_bits  - tree state after touching access_way
// Revision : 1.0 - initial release
// ============================================================================
module bp_plru #(
    parameter int WAYS   = 2,
    parameter int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] next_bits
);

    if (WAYS == 1) begin : g_single
        // Direct-mapped: nothing to choose and nothing to track.
        logic unused_plru;
        assign unused_plru = ^{plru_bits, access_way};
        assign victim      = '0;
        assign next_bits   = '0;
    end else begin : g_tree
        localparam int LEVELS = $clog2(WAYS);

        // Follow the node bits from the root; each step appends one way bit.
        always_comb begin
            int                node;
            logic [PLRU_W-1:0] bits_sh;
            logic              dir;
            node    = 0;
            bits_sh = '0;
            dir     = 1'b0;
            victim  = '0;
            for (int l = 0; l < LEVELS; l++) begin
                bits_sh = plru_bits >> node;
                dir     = bits_sh[0];
                victim  = WAY_W'({victim, dir});
                node    = 2 * node + 1 + (dir ? 1 : 0);
            end
        end

        // Walk the accessed way's path and point every node on it away.
        always_comb begin
            int                node;
            logic [WAY_W-1:0]  way_sh;
            logic [PLRU_W-1:0] mask;
            logic              dir;
            node      = 0;
            way_sh    = '0;
            mask      = '0;
            dir       = 1'b0;
            next_bits = plru_bits;
            for (int l = 0; l < LEVELS; l++) begin
                way_sh    = access_way >> (LEVELS - 1 - l);
                dir       = way_sh[0];
                mask      = PLRU_W'(1) << node;
                next_bits = dir ? (next_bits & ~mask) : (next_bits | mask);
                node      = 2 * node + 1 + (dir ? 1 : 0);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : bp_btb_assoc
// Purpose  : Set-associative branch target buffer with saturating taken
//            counters and tree-PLRU replacement; fetch-stage predictor.
//            Every resolved branch trains it; a multi-cycle sweep
//            invalidates all sets.
// Ports    : clk, RESET_N (async, active low)
//            PC_F -> PrPCSrc_F / PrALUResult_F : combinational prediction
//            Branch_E, PC_E, PCSrc_E, ALUResult_E : resolved-branch update
//            Flush_req -> Busy : invalidate sweep control / status
//            Stat_Upd, Stat_Alloc, Stat_Hit : only with BP_STATS_EN
// Options  : `define BP_STATS_EN to compile in the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module bp_btb_assoc
    import bp_pkg::*;
#(
    parameter int ENTRY_BITS = 4,
    parameter int WAYS       = 2,
    parameter int CTR_BITS   = 2
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [31:0] PC_F,
    output logic        PrPCSrc_F,
    output logic [31:0] PrALUResult_F,
    input  logic        Branch_E,
    input  logic [31:0] PC_E,
    input  logic        PCSrc_E,
    input  logic [31:0] ALUResult_E,
    input  logic        Flush_req,
    output logic        Busy
`ifdef BP_STATS_EN
    ,
    output logic [31:0] Stat_Upd,
    output logic [31:0] Stat_Alloc,
    output logic [31:0] Stat_Hit
`endif
);

    localparam int SETS   = 1 << ENTRY_BITS;
    localparam int TAG_W  = 30 - ENTRY_BITS;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam logic [CTR_BITS-1:0] CTR_T    = CTR_BITS'(ctr_thresh(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_thresh(CTR_BITS) - 1);

    if (!ways_legal(WAYS) || CTR_BITS < 2) begin : g_bad_params
        $error("bp_btb_assoc: WAYS must be 1/2/4/8 and CTR_BITS >= 2");
    end

    logic [WAYS-1:0]     valid_q  [SETS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [31:0]         target_q [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
    logic [PLRU_W-1:0]   plru_q   [SETS];

    sweep_state_t          state, state_nx;
    logic [ENTRY_BITS-1:0] sweep_idx;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

    assign Busy = (state == SWEEP);

    // ---------------- fetch lookup ----------------
    logic [ENTRY_BITS-1:0] idx_f;
    logic [TAG_W-1:0]      tag_f;
    logic                  hit_f, pred_taken;
    logic [WAY_W-1:0]      way_f;

    assign idx_f = PC_F[ENTRY_BITS+1:2];
    assign tag_f = PC_F[31:ENTRY_BITS+2];

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        hit_f = 1'b0;
        way_f = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_f][w] && (tag_q[idx_f][w] == tag_f)) begin
                hit_f = 1'b1;
                way_f = WAY_W'(w);
            end
        end
    end

    assign pred_taken    = hit_f && (ctr_q[idx_f][way_f] >= CTR_T) && !Busy;
    assign PrPCSrc_F     = pred_taken;
    assign PrALUResult_F = pred_taken ? target_q[idx_f][way_f] : 32'h0;

    // ---------------- execute lookup ----------------
    logic [ENTRY_BITS-1:0] idx_e;
    logic [TAG_W-1:0]      tag_e;
    logic                  hit_e, have_inv;
    logic [WAY_W-1:0]      way_e, inv_way, victim_way, alloc_way, touch_way;
    logic [PLRU_W-1:0]     plru_next;
    logic                  upd_en, do_hit, do_alloc;

    assign idx_e = PC_E[ENTRY_BITS+1:2];
    assign tag_e = PC_E[31:ENTRY_BITS+2];

    always_comb begin
        hit_e    = 1'b0;
        way_e    = '0;
        have_inv = 1'b0;
        inv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_e][w] && (tag_q[idx_e][w] == tag_e)) begin
                hit_e = 1'b1;
                way_e = WAY_W'(w);
            end
            if (!valid_q[idx_e][w]) begin
                have_inv = 1'b1;
                inv_way  = WAY_W'(w);
            end
        end
    end

    assign alloc_way = have_inv ? inv_way : victim_way;
    assign touch_way = hit_e ? way_e : alloc_way;

    bp_plru #(
        .WAYS   (WAYS),
        .WAY_W  (WAY_W),
        .PLRU_W (PLRU_W)
    ) u_plru (
        .plru_bits  (plru_q[idx_e]),
        .access_way (touch_way),
        .victim     (victim_way),
        .next_bits  (plru_next)
    );

    // A flush request in the same cycle takes priority over the update.
    assign upd_en   = Branch_E && (state == IDLE) && !Flush_req;
    assign do_hit   = upd_en && hit_e;
    assign do_alloc = upd_en && !hit_e && PCSrc_E;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                sweep_idx <= '0;
            end else begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Flush_req)   state_nx = SWEEP;
            SWEEP:   if (&sweep_idx)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- state arrays ----------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    ctr_q[s][w] <= CTR_INIT;
                end
            end
        end else if (state == SWEEP) begin
            valid_q[sweep_idx] <= '0;
            plru_q[sweep_idx]  <= '0;
        end else if (do_hit) begin
            if (PCSrc_E) begin
                if (ctr_q[idx_e][way_e] != CTR_MAX)
                    ctr_q[idx_e][way_e] <= ctr_q[idx_e][way_e] + 1'b1;
            end else begin
                if (ctr_q[idx_e][way_e] != '0)
                    ctr_q[idx_e][way_e] <= ctr_q[idx_e][way_e] - 1'b1;
            end
            plru_q[idx_e] <= plru_next;
        end else if (do_alloc) begin
            valid_q[idx_e][alloc_way] <= 1'b1;
            ctr_q[idx_e][alloc_way]   <= CTR_T;
            plru_q[idx_e]             <= plru_next;
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (do_hit && PCSrc_E) begin
            target_q[idx_e][way_e] <= ALUResult_E;
        end else if (do_alloc) begin
            tag_q[idx_e][alloc_way]    <= tag_e;
            target_q[idx_e][alloc_way] <= ALUResult_E;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            Stat_Upd   <= '0;
            Stat_Alloc <= '0;
            Stat_Hit   <= '0;
        end else if ((state == IDLE) && Flush_req) begin
            Stat_Upd   <= '0;
            Stat_Alloc <= '0;
            Stat_Hit   <= '0;
        end else begin
            Stat_Upd   <= Stat_Upd   + 32'(upd_en);
            Stat_Alloc <= Stat_Alloc + 32'(do_alloc);
            Stat_Hit   <= Stat_Hit   + 32'(do_hit);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_btb_assoc
// Purpose  : Directed self-checking bench for bp_btb_assoc with
//            ENTRY_BITS=4, WAYS=2, CTR_BITS=2 (threshold 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_btb_assoc;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic [31:0] PC_F;
    logic        PrPCSrc_F;
    logic [31:0] PrALUResult_F;
    logic        Branch_E;
    logic [31:0] PC_E;
    logic        PCSrc_E;
    logic [31:0] ALUResult_E;
    logic        Flush_req;
    logic        Busy;
`ifdef BP_STATS_EN
    logic [31:0] Stat_Upd, Stat_Alloc, Stat_Hit;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bp_btb_assoc #(
        .ENTRY_BITS (4),
        .WAYS       (2),
        .CTR_BITS   (2)
    ) dut (
        .clk           (clk),
        .RESET_N       (RESET_N),
        .PC_F          (PC_F),
        .PrPCSrc_F     (PrPCSrc_F),
        .PrALUResult_F (PrALUResult_F),
        .Branch_E      (Branch_E),
        .PC_E          (PC_E),
        .PCSrc_E       (PCSrc_E),
        .ALUResult_E   (ALUResult_E),
        .Flush_req     (Flush_req),
        .Busy          (Busy)
`ifdef BP_STATS_EN
        ,
        .Stat_Upd      (Stat_Upd),
        .Stat_Alloc    (Stat_Alloc),
        .Stat_Hit      (Stat_Hit)
`endif
    );

    // Stimulus helpers (no checking inside). Tasks start and end 1 time unit
    // after a rising edge.
    task automatic apply_reset();
        RESET_N     = 1'b0;
        Branch_E    = 1'b0;
        PCSrc_E     = 1'b0;
        PC_E        = 32'h0;
        ALUResult_E = 32'h0;
        Flush_req   = 1'b0;
        @(posedge clk);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        Branch_E    = 1'b1;
        PC_E        = pc;
        PCSrc_E     = taken;
        ALUResult_E = tgt;
        @(posedge clk);
        #1;
        Branch_E = 1'b0;
        PCSrc_E  = 1'b0;
    endtask

    task automatic test_reset();
        PC_F = 32'h100;
        apply_reset();
        RESET_N = 1'b0;
        #1;
        tests++;
        if ({Busy, PrPCSrc_F, PrALUResult_F} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_held busy/taken/target=%b/%b/%h required 0/0/0", Busy, PrPCSrc_F, PrALUResult_F);
        end
        RESET_N = 1'b1;
        @(posedge clk);
        #2;
        tests++;
        if ({Busy, PrPCSrc_F, PrALUResult_F} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_release busy/taken/target=%b/%b/%h required 0/0/0", Busy, PrPCSrc_F, PrALUResult_F);
        end
`ifdef BP_STATS_EN
        tests++;
        if ({Stat_Upd, Stat_Alloc, Stat_Hit} !== 96'h0) begin
            fails++;
            $display("FAIL reset_stats upd/alloc/hit=%0d/%0d/%0d required 0/0/0", Stat_Upd, Stat_Alloc, Stat_Hit);
        end
`endif
    endtask

    task automatic test_alloc_predict();
        apply_reset();
        PC_F        = 32'h40;
        Branch_E    = 1'b1;
        PC_E        = 32'h40;
        PCSrc_E     = 1'b1;
        ALUResult_E = 32'h200;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL alloc_same_cycle taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        @(posedge clk);
        #1;
        Branch_E = 1'b0;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'h200}) begin
            fails++;
            $display("FAIL alloc_predict taken/target=%b/%h required 1/00000200", PrPCSrc_F, PrALUResult_F);
        end
        PC_F = 32'h44;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL alloc_other_set taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        PC_F = 32'h440;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL alloc_tag_differs taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
    endtask

    task automatic test_replacement();
        apply_reset();
        branch(32'h40, 1'b1, 32'h400);
        branch(32'h80, 1'b1, 32'h800);
        branch(32'h80, 1'b1, 32'h880);
        branch(32'h140, 1'b0, 32'h999);
        branch(32'hC0, 1'b1, 32'hC00);
        PC_F = 32'h40;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL repl_evicted taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        PC_F = 32'h80;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'h880}) begin
            fails++;
            $display("FAIL repl_kept taken/target=%b/%h required 1/00000880", PrPCSrc_F, PrALUResult_F);
        end
        PC_F = 32'hC0;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'hC00}) begin
            fails++;
            $display("FAIL repl_new taken/target=%b/%h required 1/00000c00", PrPCSrc_F, PrALUResult_F);
        end
        PC_F = 32'h140;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL repl_nt_miss_alloc taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        // Allocating 0xC0 touched way 0, so the next victim is 0x80's way.
        branch(32'h100, 1'b1, 32'h1000);
        PC_F = 32'h80;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL repl_second_victim taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        PC_F = 32'hC0;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'hC00}) begin
            fails++;
            $display("FAIL repl_second_kept taken/target=%b/%h required 1/00000c00", PrPCSrc_F, PrALUResult_F);
        end
    endtask

    task automatic test_counter_sat();
        apply_reset();
        PC_F = 32'h40;
        branch(32'h40, 1'b1, 32'h200);
        branch(32'h40, 1'b0, 32'h999);
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL ctr_one taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        for (int i = 0; i < 3; i++) branch(32'h40, 1'b1, 32'h300);
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'h300}) begin
            fails++;
            $display("FAIL ctr_three taken/target=%b/%h required 1/00000300", PrPCSrc_F, PrALUResult_F);
        end
        branch(32'h40, 1'b0, 32'h999);
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'h300}) begin
            fails++;
            $display("FAIL ctr_sat_high taken/target=%b/%h required 1/00000300", PrPCSrc_F, PrALUResult_F);
        end
        for (int i = 0; i < 3; i++) branch(32'h40, 1'b0, 32'h999);
        branch(32'h40, 1'b1, 32'h500);
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL ctr_sat_low taken/target=%b/%h required 0/0", PrPCSrc_F, PrALUResult_F);
        end
        branch(32'h40, 1'b1, 32'h600);
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'h600}) begin
            fails++;
            $display("FAIL ctr_recover taken/target=%b/%h required 1/00000600", PrPCSrc_F, PrALUResult_F);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        apply_reset();
        branch(32'h40, 1'b1, 32'h200);
        branch(32'h84, 1'b1, 32'h280);
        PC_F = 32'h84;
        #1;
        tests++;
        if ({PrPCSrc_F, PrALUResult_F} !== {1'b1, 32'h280}) begin
            fails++;
            $display("FAIL flush_pre_hit taken/target=%b/%h required 1/00000280", PrPCSrc_F, PrALUResult_F);
        end
        Flush_req = 1'b1;
        @(posedge clk);
        #1;
        Flush_req   = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                Branch_E    = 1'b1;
                PC_E        = 32'hC8;
                PCSrc_E     = 1'b1;
                ALUResult_E = 32'hC80;
            end
            if (i == 4) begin
                Branch_E = 1'b0;
                PCSrc_E  = 1'b0;
            end
            Flush_req = (i == 5);
            #1;
            if (Busy === 1'b1) busy_cycles++;
            tests++;
            if ({PrPCSrc_F, PrALUResult_F} !== {1'b0, 32'h0}) begin
                fails++;
                $display("FAIL flush_pred_forced cycle %0d taken/target=%b/%h required 0/0", i, PrPCSrc_F, PrALUResult_F);
            end
            @(posedge clk);
            #1;
        end
        Flush_req = 1'b0;
        tests++;
        if (busy_cycles != 16 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy_len busy_cycles=%0d busy_after=%b required 16/0", busy_cycles, Busy);
        end
        PC_F = 32'h40;
        #1;
        tests++;
        if (PrPCSrc_F !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear_40 taken=%b required 0", PrPCSrc_F);
        end
        PC_F = 32'h84;
        #1;
        tests++;
        if (PrPCSrc_F !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear_84 taken=%b required 0", PrPCSrc_F);
        end
        PC_F = 32'hC8;
        #1;
        tests++;
        if (PrPCSrc_F !== 1'b0) begin
            fails++;
            $display("FAIL flush_branch_dropped taken=%b required 0", PrPCSrc_F);
        end
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        branch(32'h40, 1'b1, 32'h200);
        Flush_req = 1'b1;
        @(posedge clk);
        #1;
        Flush_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        RESET_N = 1'b0;
        #1;
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL midsweep_reset busy=%b required 0", Busy);
        end
        @(posedge clk);
        #1;
        RESET_N = 1'b1;
        PC_F    = 32'h40;
        @(posedge clk);
        #1;
        tests++;
        if ({Busy, PrPCSrc_F} !== 2'b00) begin
            fails++;
            $display("FAIL midsweep_after busy/taken=%b/%b required 0/0", Busy, PrPCSrc_F);
        end
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        apply_reset();
        branch(32'h40, 1'b1, 32'h200);
        branch(32'h40, 1'b1, 32'h200);
        tests++;
        if ({Stat_Upd, Stat_Alloc, Stat_Hit} !== {32'd2, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL stats_count upd/alloc/hit=%0d/%0d/%0d required 2/1/1", Stat_Upd, Stat_Alloc, Stat_Hit);
        end
        Flush_req = 1'b1;
        @(posedge clk);
        #1;
        Flush_req = 1'b0;
        tests++;
        if ({Stat_Upd, Stat_Alloc, Stat_Hit} !== 96'h0) begin
            fails++;
            $display("FAIL stats_sweep_clear upd/alloc/hit=%0d/%0d/%0d required 0/0/0", Stat_Upd, Stat_Alloc, Stat_Hit);
        end
        for (int n = 0; n < 40 && Busy === 1'b1; n++) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL stats_sweep_end busy=%b required 0", Busy);
        end
    endtask
`endif

    initial begin
        RESET_N     = 1'b0;
        PC_F        = 32'h0;
        Branch_E    = 1'b0;
        PC_E        = 32'h0;
        PCSrc_E     = 1'b0;
        ALUResult_E = 32'h0;
        Flush_req   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alloc_predict();
        test_replacement();
        test_counter_sat();
        test_flush();
        test_reset_mid_sweep();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
